// File: rtl/ucaspian_step_ctrl.sv
// Time-step scheduler: accumulates host target time, waits for pipeline quiescence, pulses next_step.
// Optional stall watchdog built only when STEP_WATCHDOG_EN is defined.
module ucaspian_step_ctrl #(
    parameter int TIME_W      = 32,
    parameter int TARGET_W    = 8,
    parameter int NUM_DONE    = 5,
    parameter int SETTLE      = 2,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [NUM_DONE-1:0] stage_done,
    input  logic                out_busy,
    input  logic [TARGET_W-1:0] target_value,
    input  logic                target_waiting,
    output logic                target_ack,
    output logic                next_step,
    output logic [TIME_W-1:0]   time_current,
    output logic                time_remaining,
    output logic                time_update,
    input  logic                time_sent,
    output logic                core_active,
    output logic                stall_err
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STEP   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [TIME_W-1:0]   target_time_q, target_time_d;
    logic [TIME_W-1:0]   time_current_q, time_current_d;
    logic                time_remaining_q, time_remaining_d;
    logic                time_update_q, time_update_d;
    logic                target_ack_q, target_ack_d;
    logic                all_quiet;
    logic [TIME_W:0]     target_sum;

    assign all_quiet  = (&stage_done) && !out_busy;
    assign target_sum = {1'b0, target_time_q} + {{(TIME_W + 1 - TARGET_W){1'b0}}, target_value};

    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        target_time_d  = target_time_q;
        time_current_d = time_current_q;
        time_update_d  = time_update_q;
        target_ack_d   = 1'b0;

        // The ack flop doubles as a one-cycle accept lockout.
        if (target_waiting && !target_ack_q) begin
            target_time_d = target_sum[TIME_W] ? '1 : target_sum[TIME_W-1:0];
            target_ack_d  = 1'b1;
        end

        if (time_sent && time_update_q) begin
            time_update_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (time_remaining_q) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!all_quiet) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_STEP;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_STEP: begin
                time_current_d = time_current_q + 1'b1;
                time_update_d  = 1'b1;
                state_d        = ST_HOLD;
            end
            ST_HOLD: begin
                if (!time_update_q) begin
                    state_d      = time_remaining_q ? ST_SETTLE : ST_IDLE;
                    settle_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d        = ST_IDLE;
            settle_cnt_d   = '0;
            target_time_d  = '0;
            time_current_d = '0;
            time_update_d  = 1'b0;
            target_ack_d   = 1'b0;
        end

        time_remaining_d = target_time_d > time_current_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            settle_cnt_q     <= '0;
            target_time_q    <= '0;
            time_current_q   <= '0;
            time_remaining_q <= 1'b0;
            time_update_q    <= 1'b0;
            target_ack_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            settle_cnt_q     <= settle_cnt_d;
            target_time_q    <= target_time_d;
            time_current_q   <= time_current_d;
            time_remaining_q <= time_remaining_d;
            time_update_q    <= time_update_d;
            target_ack_q     <= target_ack_d;
        end
    end

    assign target_ack     = target_ack_q && !clear;
    assign next_step      = (state_q == ST_STEP) && !clear;
    assign time_current   = time_current_q;
    assign time_remaining = time_remaining_q;
    assign time_update    = time_update_q;
    assign core_active    = (state_q != ST_IDLE) && !clear;

`ifdef STEP_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);

    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        stall_err_q, stall_err_d;

    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        stall_err_d = stall_err_q;
        if (state_q == ST_SETTLE) begin
            if (state_d == ST_STEP) begin
                wdog_cnt_d = '0;
            end else if (wdog_cnt_q != 16'hFFFF) begin
                wdog_cnt_d = wdog_cnt_q + 16'd1;
            end
        end
        if (wdog_cnt_d == WDOG_LIM && state_q == ST_SETTLE && state_d != ST_STEP) begin
            stall_err_d = 1'b1;
        end
        if (clear) begin
            wdog_cnt_d  = '0;
            stall_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt_q  <= '0;
            stall_err_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`else
    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Directed bench for ucaspian_step_ctrl: reset, stepping, settle gating, host backpressure,
// accept rate, saturation (narrow instance) and clear; watchdog when STEP_WATCHDOG_EN is defined.
module tb_ucaspian_step_ctrl;

`ifdef STEP_WATCHDOG_EN
    localparam int WD = 10;
`else
    localparam int WD = 65535;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [4:0]  stage_done = 5'h1f;
    logic        out_busy = 1'b0;
    logic [7:0]  target_value = 8'd0;
    logic        target_waiting = 1'b0;
    logic        target_ack;
    logic        next_step;
    logic [31:0] time_current;
    logic        time_remaining;
    logic        time_update;
    logic        time_sent = 1'b0;
    logic        core_active;
    logic        stall_err;

    logic [7:0]  s_target_value = 8'd0;
    logic        s_target_waiting = 1'b0;
    logic        s_target_ack;
    logic        s_next_step;
    logic [8:0]  s_time_current;
    logic        s_time_remaining;
    logic        s_time_update;
    logic        s_core_active;
    logic        s_stall_err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ucaspian_step_ctrl #(.WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset), .clear(clear), .stage_done(stage_done),
        .out_busy(out_busy), .target_value(target_value), .target_waiting(target_waiting),
        .target_ack(target_ack), .next_step(next_step), .time_current(time_current),
        .time_remaining(time_remaining), .time_update(time_update), .time_sent(time_sent),
        .core_active(core_active), .stall_err(stall_err)
    );

    // Narrow time width so saturation is reachable in a few offers; it never steps.
    ucaspian_step_ctrl #(.TIME_W(9)) sat_dut (
        .clk(clk), .reset(reset), .clear(clear), .stage_done(5'b00000),
        .out_busy(1'b0), .target_value(s_target_value), .target_waiting(s_target_waiting),
        .target_ack(s_target_ack), .next_step(s_next_step), .time_current(s_time_current),
        .time_remaining(s_time_remaining), .time_update(s_time_update), .time_sent(1'b0),
        .core_active(s_core_active), .stall_err(s_stall_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        target_waiting = 1'b0;
        time_sent = 1'b0;
        stage_done = 5'h1f;
        out_busy = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic offer(input logic [7:0] v, input string name);
        target_value = v;
        target_waiting = 1'b1;
        tick();
        target_waiting = 1'b0;
        n_checks++;
        if (target_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ack: got %b expected 1", name, target_ack);
        end
    endtask

    // Runs n cycles; host returns time_sent the cycle after it sees time_update when host_en.
    task automatic run(input int n, input bit host_en, output int pulses, output int p0,
                       output int p1, output int p2);
        pulses = 0; p0 = -1; p1 = -1; p2 = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (next_step === 1'b1) begin
                if (pulses == 0) p0 = i;
                if (pulses == 1) p1 = i;
                if (pulses == 2) p2 = i;
                pulses++;
            end
            time_sent = host_en && time_update;
        end
    endtask

    task automatic test_reset();
        tick();
        n_checks++;
        if ({target_ack, next_step, time_remaining, time_update, stall_err, core_active} !== 6'b0
            || time_current !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b step=%b rem=%b upd=%b err=%b act=%b t=%0d expected all 0",
                     target_ack, next_step, time_remaining, time_update, stall_err, core_active, time_current);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        int pulses, p0, p1, p2;
        do_clear();
        offer(8'd3, "basic");
        n_checks++;
        if (time_remaining !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_remaining_set: got %b expected 1", time_remaining);
        end
        run(30, 1'b1, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 3 || p0 != 3 || p1 != 8 || p2 != 13) begin
            n_fail++;
            $display("FAIL basic_steps: got %0d pulses at %0d,%0d,%0d expected 3 at 3,8,13",
                     pulses, p0, p1, p2);
        end
        n_checks++;
        if (time_current !== 32'd3 || time_remaining !== 1'b0 || core_active !== 1'b0
            || time_update !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got t=%0d rem=%b act=%b upd=%b expected t=3 rem=0 act=0 upd=0",
                     time_current, time_remaining, core_active, time_update);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses, p0, p1, p2;
        do_clear();
        offer(8'd5, "midrst");
        run(3, 1'b1, pulses, p0, p1, p2);
        n_checks++;
        if (next_step !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_step_before: got %b expected 1", next_step);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({target_ack, next_step, time_remaining, time_update, core_active} !== 5'b0
            || time_current !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got ack=%b step=%b rem=%b upd=%b act=%b t=%0d expected all 0",
                     target_ack, next_step, time_remaining, time_update, core_active, time_current);
        end
        tick();
        reset = 1'b0;
        run(20, 1'b1, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 0 || time_current !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_no_step: got %0d pulses t=%0d expected 0 pulses t=0", pulses, time_current);
        end
    endtask

    task automatic test_settle_gating();
        int pulses;
        int p0, p1, p2;
        do_clear();
        offer(8'd1, "settle");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            stage_done[2] = ~i[0];
            tick();
            if (next_step === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || core_active !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_glitch: got %0d pulses act=%b expected 0 pulses act=1", pulses, core_active);
        end
        stage_done = 5'h1f;
        tick();
        n_checks++;
        if (next_step !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_first_quiet: got %b expected 0", next_step);
        end
        tick();
        n_checks++;
        if (next_step !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_second_quiet: got %b expected 1", next_step);
        end
        run(10, 1'b1, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 0 || time_current !== 32'd1) begin
            n_fail++;
            $display("FAIL settle_single: got %0d extra pulses t=%0d expected 0 t=1", pulses, time_current);
        end
    endtask

    task automatic test_backpressure();
        int pulses, p0, p1, p2;
        do_clear();
        offer(8'd4, "bp");
        run(10, 1'b0, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 1 || p0 != 3) begin
            n_fail++;
            $display("FAIL bp_first: got %0d pulses first at %0d expected 1 at 3", pulses, p0);
        end
        run(20, 1'b0, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 0 || time_current !== 32'd1 || time_update !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d pulses t=%0d upd=%b expected 0 t=1 upd=1",
                     pulses, time_current, time_update);
        end
        time_sent = 1'b1;
        tick();
        time_sent = 1'b0;
        n_checks++;
        if (time_update !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_sent: got upd=%b expected 0", time_update);
        end
        run(40, 1'b1, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 3 || time_current !== 32'd4 || time_remaining !== 1'b0 || stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_resume: got %0d pulses t=%0d rem=%b err=%b expected 3 t=4 rem=0 err=0",
                     pulses, time_current, time_remaining, stall_err);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        stage_done = 5'h00;
        target_value = 8'd2;
        target_waiting = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (target_ack !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL b2b_ack%0d: got %b expected %b", i, target_ack, ((i % 2) == 0));
            end
        end
        target_waiting = 1'b0;
        n_checks++;
        if (dut.target_time_q !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_target: got %0d expected 4", dut.target_time_q);
        end
    endtask

    task automatic test_saturation_clear();
        do_clear();
        s_target_value = 8'hff;
        s_target_waiting = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (sat_dut.target_time_q !== 9'd510) begin
            n_fail++;
            $display("FAIL sat_preload: got %0d expected 510", sat_dut.target_time_q);
        end
        tick(); tick();
        n_checks++;
        if (sat_dut.target_time_q !== 9'h1ff || s_target_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_value: got %0d ack=%b expected 511 ack=1", sat_dut.target_time_q, s_target_ack);
        end
        s_target_waiting = 1'b0;
        tick();
        // Main instance carries a stepped run; clear must drop it alongside a fresh offer.
        offer(8'd9, "preclr");
        run_clear_with_offer();
    endtask

    task automatic run_clear_with_offer();
        target_value = 8'd9;
        target_waiting = 1'b1;
        s_target_waiting = 1'b1;
        clear = 1'b1;
        #1;
        n_checks++;
        if (target_ack !== 1'b0 || next_step !== 1'b0 || core_active !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_cycle: got ack=%b step=%b act=%b expected 0", target_ack, next_step, core_active);
        end
        tick();
        n_checks++;
        if (target_ack !== 1'b0 || dut.target_time_q !== 32'd0 || time_current !== 32'd0
            || time_remaining !== 1'b0 || s_target_ack !== 1'b0 || sat_dut.target_time_q !== 9'd0) begin
            n_fail++;
            $display("FAIL clr_offer: got ack=%b tgt=%0d t=%0d rem=%b sack=%b stgt=%0d expected all 0",
                     target_ack, dut.target_time_q, time_current, time_remaining,
                     s_target_ack, sat_dut.target_time_q);
        end
        clear = 1'b0;
        target_waiting = 1'b0;
        s_target_waiting = 1'b0;
        tick();
    endtask

`ifdef STEP_WATCHDOG_EN
    task automatic test_watchdog();
        int pulses, p0, p1, p2;
        do_clear();
        out_busy = 1'b1;
        offer(8'd1, "wd");
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_early: got %b expected 0", stall_err);
        end
        tick();
        n_checks++;
        if (stall_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_set: got %b expected 1", stall_err);
        end
        out_busy = 1'b0;
        run(10, 1'b1, pulses, p0, p1, p2);
        n_checks++;
        if (pulses != 1 || stall_err !== 1'b1 || time_current !== 32'd1) begin
            n_fail++;
            $display("FAIL wd_sticky: got %0d pulses err=%b t=%0d expected 1 err=1 t=1",
                     pulses, stall_err, time_current);
        end
        do_clear();
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear: got %b expected 0", stall_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_reset_mid_run();
        test_settle_gating();
        test_backpressure();
        test_back_to_back();
        test_saturation_clear();
`ifdef STEP_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
